fetch_top: RTL

Instruction-fetch stage: owns the PC, issues word fetches to the instruction cache over a req/ready handshake, and registers `{pc, instruction}` into the decode stage's input each cycle. It applies the synchronous jump redirect produced by decode and the branch redirect produced by the memory stage, and holds or bubbles its output under the hazard stall.

---
 rtl/fetch_top.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fetch_top.sv
// fetch_top: instruction-fetch stage. Owns the PC, fetches words from the
// instruction cache over a req/ready handshake, and registers {pc, instr}
// into decode. Branch and jump redirects go through a DRAIN state whenever
// a cache request is still in flight. When decode stalls, the fetched word
// is parked in HOLD.
// Optional feature: define FETCH_PERF_CNT_EN to build the cache
// wait-cycle counter on fetch_wait_cnt. Without it the port is tied to 0.
module fetch_top #(
  parameter int                    ADDR_SIZE  = 32,
  parameter int                    INSTR_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0]  RESET_PC   = ADDR_SIZE'(32'h0000_1000),
  parameter logic [INSTR_SIZE-1:0] NOP_INSTR  = INSTR_SIZE'(32'h0000_0000)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  is_jump,
  input  logic [ADDR_SIZE-1:0]  jump_addr,
  input  logic                  branch,
  input  logic [ADDR_SIZE-1:0]  branch_addr,
  output logic                  ic_req,
  output logic [ADDR_SIZE-1:0]  ic_addr,
  input  logic                  ic_ready,
  input  logic [INSTR_SIZE-1:0] ic_data,
  output logic [ADDR_SIZE-1:0]  out_pc,
  output logic [INSTR_SIZE-1:0] out_instr,
  output logic                  out_valid,
  output logic [31:0]           fetch_wait_cnt
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t                  state, state_n;
  logic [ADDR_SIZE-1:0]    pc, pc_n;
  logic [ADDR_SIZE-1:0]    drain_addr, drain_addr_n;
  logic [ADDR_SIZE-1:0]    hold_pc, hold_pc_n;
  logic [INSTR_SIZE-1:0]   hold_instr, hold_instr_n;
  logic [ADDR_SIZE-1:0]    out_pc_n;
  logic [INSTR_SIZE-1:0]   out_instr_n;
  logic                    out_valid_n;
  logic                    redirect;
  logic [ADDR_SIZE-1:0]    target_raw;
  logic [ADDR_SIZE-1:0]    target;

  // The branch is older than the jump, so it wins. Targets are word aligned.
  assign redirect   = branch | is_jump;
  assign target_raw = branch ? branch_addr : jump_addr;
  assign target     = {target_raw[ADDR_SIZE-1:2], 2'b00};

  // The request depends only on registered state and reset. It never
  // depends on ic_ready, and reset masks it right away.
  assign ic_req  = reset && (state != HOLD);
  assign ic_addr = (state == DRAIN) ? drain_addr : pc;

  // Compute the next state, the PC, the hold/drain registers and the outputs.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    drain_addr_n = drain_addr;
    hold_pc_n    = hold_pc;
    hold_instr_n = hold_instr;
    out_pc_n     = out_pc;
    out_instr_n  = out_instr;
    out_valid_n  = out_valid;
    case (state)
      FETCH: begin
        if (redirect) begin
          pc_n        = target;
          out_pc_n    = target;
          out_instr_n = NOP_INSTR;
          out_valid_n = 1'b0;
          if (!ic_ready) begin
            drain_addr_n = pc;
            state_n      = DRAIN;
          end
        end else if (ic_ready) begin
          pc_n = pc + ADDR_SIZE'(4);
          if (!stall) begin
            out_pc_n    = pc;
            out_instr_n = ic_data;
            out_valid_n = 1'b1;
          end else begin
            hold_pc_n    = pc;
            hold_instr_n = ic_data;
            state_n      = HOLD;
          end
        end else if (!stall) begin
          out_instr_n = NOP_INSTR;
          out_valid_n = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_n        = target;
          out_pc_n    = target;
          out_instr_n = NOP_INSTR;
          out_valid_n = 1'b0;
          state_n     = FETCH;
        end else if (!stall) begin
          out_pc_n    = hold_pc;
          out_instr_n = hold_instr;
          out_valid_n = 1'b1;
          state_n     = FETCH;
        end
      end
      DRAIN: begin
        if (ic_ready) begin
          state_n = FETCH;
        end
        if (redirect) begin
          pc_n        = target;
          out_pc_n    = target;
          out_instr_n = NOP_INSTR;
          out_valid_n = 1'b0;
        end else if (!stall) begin
          out_instr_n = NOP_INSTR;
          out_valid_n = 1'b0;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  // Register the state, the PC and the decode-facing outputs. Reset is
  // synchronous and active low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drain_addr <= '0;
      hold_pc    <= '0;
      hold_instr <= NOP_INSTR;
      out_pc     <= '0;
      out_instr  <= NOP_INSTR;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      drain_addr <= drain_addr_n;
      hold_pc    <= hold_pc_n;
      hold_instr <= hold_instr_n;
      out_pc     <= out_pc_n;
      out_instr  <= out_instr_n;
      out_valid  <= out_valid_n;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] wait_cnt;

  // Count the cycles spent waiting on the cache. The count saturates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (ic_req && !ic_ready && (wait_cnt != 32'hFFFF_FFFF)) begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end

  assign fetch_wait_cnt = wait_cnt;
`else
  assign fetch_wait_cnt = 32'd0;
`endif

endmodule
